// File: rtl/alu_decode_unit.sv
// Purpose : opcode decoder, operand select/extend, ALU, zero flag and branch decision for the single-cycle core.
// Latency : combinational (0 cycles); only the run-enable and sticky-halt status flops are clocked.
// Backpr. : none; one instruction per cycle. Side effects are gated until run-enable and after halt.
//
// Ports: clk, rst (async, active-low); opcode/shamt/imm instruction fields; rs_data/rt_data register reads;
//        regdst/regwrite/memread/memwrite/memtoreg/jump/pcsrc datapath controls; halt, pc_hold, illegal status;
//        aluctl, alurslt, zero ALU outputs.
// Build option: define ALU_DECODE_SLL_EN to decode opcode 011000 as sll and build the shifter.
module alu_decode_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opcode,
    input  logic [4:0]  shamt,
    input  logic [15:0] imm,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        regdst,
    output logic        regwrite,
    output logic        memread,
    output logic        memwrite,
    output logic        memtoreg,
    output logic        jump,
    output logic        pcsrc,
    output logic        halt,
    output logic        pc_hold,
    output logic        illegal,
    output logic [3:0]  aluctl,
    output logic [31:0] alurslt,
    output logic        zero
);

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_SLT = 4'b0100;
    localparam logic [3:0] ALU_SLL = 4'b0101;

    typedef struct packed {
        logic       regdst;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       alusrc_a;
        logic       alusrc_b;
        logic       extsel;
        logic       branch_eq;
        logic       branch_ne;
        logic       branch_ltz;
        logic       jump;
        logic       halt;
        logic       illegal;
        logic [3:0] aluctl;
    } ctl_t;

    ctl_t        ctl;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] ext_imm;
    logic [31:0] alu_res;
    logic        branch_take;
    logic        run_ok;
    logic        working_d, working_q;
    logic        halted_d, halted_q;

    // Opcode decode; unlisted controls stay 0.
    always_comb begin
        ctl = '0;
        ctl.aluctl = ALU_ADD;
        case (opcode)
            6'b000000: begin ctl.regdst = 1'b1; ctl.regwrite = 1'b1; ctl.aluctl = ALU_ADD; end
            6'b000010: begin ctl.regdst = 1'b1; ctl.regwrite = 1'b1; ctl.aluctl = ALU_SUB; end
            6'b010001: begin ctl.regdst = 1'b1; ctl.regwrite = 1'b1; ctl.aluctl = ALU_AND; end
            6'b010011: begin ctl.regdst = 1'b1; ctl.regwrite = 1'b1; ctl.aluctl = ALU_OR;  end
`ifdef ALU_DECODE_SLL_EN
            6'b011000: begin
                ctl.regdst   = 1'b1;
                ctl.regwrite = 1'b1;
                ctl.alusrc_a = 1'b1;
                ctl.aluctl   = ALU_SLL;
            end
`endif
            6'b000001: begin ctl.regwrite = 1'b1; ctl.alusrc_b = 1'b1; ctl.extsel = 1'b1; ctl.aluctl = ALU_ADD; end
            6'b010000: begin ctl.regwrite = 1'b1; ctl.alusrc_b = 1'b1; ctl.aluctl = ALU_AND; end
            6'b010010: begin ctl.regwrite = 1'b1; ctl.alusrc_b = 1'b1; ctl.aluctl = ALU_OR;  end
            6'b011100: begin ctl.regwrite = 1'b1; ctl.alusrc_b = 1'b1; ctl.extsel = 1'b1; ctl.aluctl = ALU_SLT; end
            6'b100111: begin
                ctl.regwrite = 1'b1;
                ctl.memread  = 1'b1;
                ctl.memtoreg = 1'b1;
                ctl.alusrc_b = 1'b1;
                ctl.extsel   = 1'b1;
                ctl.aluctl   = ALU_ADD;
            end
            6'b100110: begin ctl.memwrite = 1'b1; ctl.alusrc_b = 1'b1; ctl.extsel = 1'b1; ctl.aluctl = ALU_ADD; end
            6'b110000: begin ctl.branch_eq  = 1'b1; ctl.aluctl = ALU_SUB; end
            6'b110001: begin ctl.branch_ne  = 1'b1; ctl.aluctl = ALU_SUB; end
            // bltz relies on rt being $0, so slt(rs, 0) is the sign test.
            6'b110010: begin ctl.branch_ltz = 1'b1; ctl.aluctl = ALU_SLT; end
            6'b111000: ctl.jump = 1'b1;
            6'b111111: ctl.halt = 1'b1;
            default:   begin ctl.illegal = 1'b1; ctl.aluctl = ALU_ADD; end
        endcase
    end

    // Operand selection and ALU.
    always_comb begin
        ext_imm = ctl.extsel ? {{16{imm[15]}}, imm} : {16'b0, imm};
        op_a    = ctl.alusrc_a ? {27'b0, shamt} : rs_data;
        op_b    = ctl.alusrc_b ? ext_imm : rt_data;
        alu_res = '0;
        case (ctl.aluctl)
            ALU_ADD: alu_res = op_a + op_b;
            ALU_SUB: alu_res = op_a - op_b;
            ALU_AND: alu_res = op_a & op_b;
            ALU_OR:  alu_res = op_a | op_b;
            ALU_SLT: alu_res = {31'b0, ($signed(op_a) < $signed(op_b))};
`ifdef ALU_DECODE_SLL_EN
            ALU_SLL: alu_res = op_b << op_a[4:0];
`endif
            default: alu_res = '0;
        endcase
    end

    // Status flops: run-enable rises one edge after reset release; halt is sticky until reset.
    always_comb begin
        working_d = 1'b1;
        halted_d  = halted_q | (working_q & ctl.halt);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            working_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            working_q <= working_d;
            halted_q  <= halted_d;
        end
    end

    // Outputs with side-effect gating.
    always_comb begin
        run_ok      = working_q & ~halted_q;
        zero        = (alu_res == 32'd0);
        branch_take = (ctl.branch_eq & zero) | ((ctl.branch_ne | ctl.branch_ltz) & ~zero);
        alurslt     = alu_res;
        aluctl      = ctl.aluctl;
        illegal     = ctl.illegal;
        regdst      = ctl.regdst;
        memtoreg    = ctl.memtoreg;
        regwrite    = ctl.regwrite & run_ok;
        memread     = ctl.memread  & run_ok;
        memwrite    = ctl.memwrite & run_ok;
        jump        = ctl.jump     & run_ok;
        pcsrc       = branch_take  & run_ok;
        halt        = ctl.halt | halted_q;
        pc_hold     = ~working_q | halt;
    end

endmodule

// File: tb/tb_alu_decode_unit.sv
// Purpose : directed self-checking bench for alu_decode_unit.
// Latency : checks combinational outputs 1 time unit after inputs change, away from the rising edge.
// Backpr. : none.
module tb_alu_decode_unit;

    logic        clk;
    logic        rst;
    logic [5:0]  opcode;
    logic [4:0]  shamt;
    logic [15:0] imm;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        regdst, regwrite, memread, memwrite, memtoreg;
    logic        jump, pcsrc, halt, pc_hold, illegal, zero;
    logic [3:0]  aluctl;
    logic [31:0] alurslt;

    int n_chk = 0;
    int n_bad = 0;

    alu_decode_unit dut (
        .clk      (clk),
        .rst      (rst),
        .opcode   (opcode),
        .shamt    (shamt),
        .imm      (imm),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .regdst   (regdst),
        .regwrite (regwrite),
        .memread  (memread),
        .memwrite (memwrite),
        .memtoreg (memtoreg),
        .jump     (jump),
        .pcsrc    (pcsrc),
        .halt     (halt),
        .pc_hold  (pc_hold),
        .illegal  (illegal),
        .aluctl   (aluctl),
        .alurslt  (alurslt),
        .zero     (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // Drive one instruction at the falling edge, then settle.
    task automatic drive(input logic [5:0] op, input logic [4:0] sh, input logic [15:0] im,
                         input logic [31:0] rs, input logic [31:0] rt);
        @(negedge clk);
        opcode  = op;
        shamt   = sh;
        imm     = im;
        rs_data = rs;
        rt_data = rt;
        #1;
    endtask

    initial begin
        rst = 1'b0;
        opcode = 6'b000000; shamt = '0; imm = '0; rs_data = 32'd1; rt_data = 32'd2;

        // Reset state
        drive(6'b000000, 5'd0, 16'h0, 32'd1, 32'd2);
        chk("rst_pc_hold",  {31'b0, pc_hold},  32'd1);
        chk("rst_regwrite", {31'b0, regwrite}, 32'd0);
        chk("rst_halt",     {31'b0, halt},     32'd0);
        chk("rst_alurslt",  alurslt,           32'd3);
        chk("rst_regdst",   {31'b0, regdst},   32'd1);

        // Release between edges: the cycle before the next rising edge is still suppressed.
        rst = 1'b1;
        #1;
        chk("rel0_pc_hold",  {31'b0, pc_hold},  32'd1);
        chk("rel0_regwrite", {31'b0, regwrite}, 32'd0);

        // add wrap to zero
        drive(6'b000000, 5'd0, 16'h0, 32'hFFFF_FFFF, 32'd1);
        chk("run_pc_hold",  {31'b0, pc_hold},  32'd0);
        chk("add_regwrite", {31'b0, regwrite}, 32'd1);
        chk("add_rslt",     alurslt,           32'd0);
        chk("add_zero",     {31'b0, zero},     32'd1);

        // addiu with -2
        drive(6'b000001, 5'd0, 16'hFFFE, 32'd10, 32'd99);
        chk("addiu_rslt",   alurslt,           32'd8);
        chk("addiu_regdst", {31'b0, regdst},   32'd0);
        chk("addiu_zero",   {31'b0, zero},     32'd0);

        // ori zero-extends
        drive(6'b010010, 5'd0, 16'h8000, 32'd0, 32'd0);
        chk("ori_rslt",   alurslt,        32'h0000_8000);
        chk("ori_aluctl", {28'b0, aluctl}, 32'd3);

        // andi zero-extends
        drive(6'b010000, 5'd0, 16'h8001, 32'hFFFF_FFFF, 32'd0);
        chk("andi_rslt", alurslt, 32'h0000_8001);

        // sub wraps
        drive(6'b000010, 5'd0, 16'h0, 32'd5, 32'd7);
        chk("sub_rslt", alurslt, 32'hFFFF_FFFE);

        // or / and register forms
        drive(6'b010011, 5'd0, 16'h0, 32'h0F00_00F0, 32'h0000_0F0F);
        chk("or_rslt", alurslt, 32'h0F00_0FFF);
        drive(6'b010001, 5'd0, 16'h0, 32'hFF00_FF00, 32'h0F0F_0F0F);
        chk("and_rslt", alurslt, 32'h0F00_0F00);

        // slti signed compare
        drive(6'b011100, 5'd0, 16'd3, 32'hFFFF_FFFB, 32'd0);
        chk("slti_lt",     alurslt,         32'd1);
        chk("slti_aluctl", {28'b0, aluctl}, 32'd4);
        drive(6'b011100, 5'd0, 16'd3, 32'd5, 32'd0);
        chk("slti_ge", alurslt, 32'd0);

        // sll opcode: shifts when enabled, illegal (add of rs+rt, no write) otherwise
        drive(6'b011000, 5'd4, 16'h0, 32'd0, 32'd1);
`ifdef ALU_DECODE_SLL_EN
        chk("sll_rslt",     alurslt,           32'h10);
        chk("sll_illegal",  {31'b0, illegal},  32'd0);
        chk("sll_regwrite", {31'b0, regwrite}, 32'd1);
`else
        chk("sll_illegal",  {31'b0, illegal},  32'd1);
        chk("sll_regwrite", {31'b0, regwrite}, 32'd0);
        chk("sll_rslt",     alurslt,           32'd1);
`endif

        // unknown opcode
        drive(6'b101010, 5'd0, 16'h0, 32'd4, 32'd5);
        chk("ill_flag",     {31'b0, illegal},  32'd1);
        chk("ill_regwrite", {31'b0, regwrite}, 32'd0);
        chk("ill_aluctl",   {28'b0, aluctl},   32'd0);
        chk("ill_rslt",     alurslt,           32'd9);

        // branches
        drive(6'b110000, 5'd0, 16'h0, 32'd42, 32'd42);
        chk("beq_eq",  {31'b0, pcsrc}, 32'd1);
        drive(6'b110000, 5'd0, 16'h0, 32'd42, 32'd43);
        chk("beq_ne",  {31'b0, pcsrc}, 32'd0);
        drive(6'b110001, 5'd0, 16'h0, 32'd42, 32'd42);
        chk("bne_eq",  {31'b0, pcsrc}, 32'd0);
        drive(6'b110001, 5'd0, 16'h0, 32'd42, 32'd43);
        chk("bne_ne",  {31'b0, pcsrc}, 32'd1);
        drive(6'b110010, 5'd0, 16'h0, 32'h8000_0000, 32'd0);
        chk("bltz_neg", {31'b0, pcsrc}, 32'd1);
        drive(6'b110010, 5'd0, 16'h0, 32'd5, 32'd0);
        chk("bltz_pos", {31'b0, pcsrc}, 32'd0);

        // memory
        drive(6'b100111, 5'd0, 16'hFFFC, 32'h0000_1000, 32'd0);
        chk("lw_rslt",     alurslt,           32'h0000_0FFC);
        chk("lw_memread",  {31'b0, memread},  32'd1);
        chk("lw_memtoreg", {31'b0, memtoreg}, 32'd1);
        chk("lw_regwrite", {31'b0, regwrite}, 32'd1);
        drive(6'b100110, 5'd0, 16'h0010, 32'h0000_2000, 32'd7);
        chk("sw_memwrite", {31'b0, memwrite}, 32'd1);
        chk("sw_regwrite", {31'b0, regwrite}, 32'd0);
        chk("sw_rslt",     alurslt,           32'h0000_2010);

        // jump
        drive(6'b111000, 5'd0, 16'h0, 32'd0, 32'd0);
        chk("j_jump", {31'b0, jump}, 32'd1);

        // halt: combinational in its own cycle, then latched
        drive(6'b111111, 5'd0, 16'h0, 32'd0, 32'd0);
        chk("halt_now",    {31'b0, halt},    32'd1);
        chk("halt_pchold", {31'b0, pc_hold}, 32'd1);
        drive(6'b000000, 5'd0, 16'h0, 32'd1, 32'd1);
        chk("halted_regwrite", {31'b0, regwrite}, 32'd0);
        chk("halted_halt",     {31'b0, halt},     32'd1);
        chk("halted_pchold",   {31'b0, pc_hold},  32'd1);
        drive(6'b110000, 5'd0, 16'h0, 32'd3, 32'd3);
        chk("halted_pcsrc", {31'b0, pcsrc}, 32'd0);

        // asynchronous reset mid-cycle clears the halt
        drive(6'b000000, 5'd0, 16'h0, 32'd1, 32'd1);
        rst = 1'b0;
        #1;
        chk("arst_halt",   {31'b0, halt},    32'd0);
        chk("arst_pchold", {31'b0, pc_hold}, 32'd1);
        rst = 1'b1;
        #1;
        chk("arst_rel_regwrite", {31'b0, regwrite}, 32'd0);
        drive(6'b000000, 5'd0, 16'h0, 32'd1, 32'd1);
        chk("resume_regwrite", {31'b0, regwrite}, 32'd1);
        chk("resume_pchold",   {31'b0, pc_hold},  32'd0);
        chk("resume_rslt",     alurslt,           32'd2);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
